// File: rtl/sysbus_arbiter_if.sv
// Shared system-bus signals between the MARIA/CPU side (master) and sysbus_arbiter (slave).
// Handshake: dma_req is a level request held by MARIA; the bus belongs to MARIA only while dma_grant is high.
`timescale 1ns/1ps
interface sysbus_arbiter_if #(
    parameter int CS_W = 4
);
    logic            pclk_0;
    logic            dma_req;
    logic [15:0]     dma_addr;
    logic [15:0]     cpu_addr;
    logic            cpu_rw;
    logic [CS_W-1:0] cs_in;
    logic [15:0]     ab_out;
    logic            rw_out;
    logic            halt_b;
    logic            dma_grant;
    logic            dma_latch;
    logic [CS_W-1:0] cs_rd;
    logic            wr_block;
    logic            starved;

    modport slave (
        input  pclk_0, dma_req, dma_addr, cpu_addr, cpu_rw, cs_in,
        output ab_out, rw_out, halt_b, dma_grant, dma_latch, cs_rd, wr_block, starved
    );

    modport master (
        output pclk_0, dma_req, dma_addr, cpu_addr, cpu_rw, cs_in,
        input  ab_out, rw_out, halt_b, dma_grant, dma_latch, cs_rd, wr_block, starved
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// Hands the system bus between the 6502 and MARIA DMA, halting the CPU on a phi0 boundary.
// Optional burst-length starvation guard: define STARVE_GUARD_EN.
`timescale 1ns/1ps
module sysbus_arbiter #(
    parameter int CS_W        = 4,
    parameter int TAIL_CYCLES = 1,
    parameter int MAX_BURST   = 255
) (
    input  logic               sysclk_7_143,
    input  logic               rst,
    sysbus_arbiter_if.slave    bus,
    output logic [2:0]         dbg_state_o,
    output logic [7:0]         dbg_burst_o
);
`ifdef STARVE_GUARD_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, SYNC = 3'd1, DMA = 3'd2, TAIL = 3'd3, RESUME = 3'd4
    } state_t;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, SYNC = 3'd1, DMA = 3'd2, TAIL = 3'd3
    } state_t;
`endif

    localparam logic [1:0] TAIL_LOAD = 2'(TAIL_CYCLES - 1);

    if (TAIL_CYCLES < 1 || TAIL_CYCLES > 3) begin : g_bad_tail
        $error("sysbus_arbiter: TAIL_CYCLES out of range 1-3");
    end
    if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_burst
        $error("sysbus_arbiter: MAX_BURST out of range 2-255");
    end

    state_t          state_q;
    logic            p0_q;
    logic            boundary;
    logic            halt_q;
    logic            grant_q;
    logic            latch_q;
    logic            starved_q;
    logic [1:0]      tail_q;
    logic [7:0]      burst_q;
    logic [7:0]      burst_inc;
    logic [CS_W-1:0] cs_q;
`ifdef STARVE_GUARD_EN
    logic            cut_q;
    logic            seen_q;
`endif

    assign boundary  = bus.pclk_0 & ~p0_q;
    assign burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;

    always_ff @(posedge sysclk_7_143 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            p0_q      <= 1'b0;
            halt_q    <= 1'b1;
            grant_q   <= 1'b0;
            latch_q   <= 1'b0;
            starved_q <= 1'b0;
            tail_q    <= 2'd0;
            burst_q   <= 8'd0;
            cs_q      <= '0;
`ifdef STARVE_GUARD_EN
            cut_q     <= 1'b0;
            seen_q    <= 1'b0;
`endif
        end else begin
            p0_q      <= bus.pclk_0;
            cs_q      <= bus.cs_in;
            latch_q   <= grant_q;
            starved_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.dma_req) begin
                        state_q <= SYNC;
                        halt_q  <= 1'b0;
                    end
                end
                SYNC: begin
                    // A dropping request beats a coincident boundary.
                    if (!bus.dma_req) begin
                        state_q <= IDLE;
                        halt_q  <= 1'b1;
                    end else if (boundary) begin
                        state_q <= DMA;
                        grant_q <= 1'b1;
                        burst_q <= 8'd0;
                    end
                end
                DMA: begin
                    burst_q <= burst_inc;
`ifdef STARVE_GUARD_EN
                    if (burst_q == BURST_LAST) begin
                        state_q   <= TAIL;
                        tail_q    <= TAIL_LOAD;
                        cut_q     <= 1'b1;
                        starved_q <= 1'b1;
                    end else
`endif
                    if (!bus.dma_req) begin
                        state_q <= TAIL;
                        tail_q  <= TAIL_LOAD;
                    end
                end
                TAIL: begin
`ifdef STARVE_GUARD_EN
                    if (bus.dma_req && !cut_q) begin
                        state_q <= DMA;
                    end else if (tail_q == 2'd0) begin
                        state_q <= cut_q ? RESUME : IDLE;
                        cut_q   <= 1'b0;
                        seen_q  <= 1'b0;
                        halt_q  <= 1'b1;
                        grant_q <= 1'b0;
                    end else begin
                        tail_q <= tail_q - 2'd1;
                    end
`else
                    if (bus.dma_req) begin
                        state_q <= DMA;
                    end else if (tail_q == 2'd0) begin
                        state_q <= IDLE;
                        halt_q  <= 1'b1;
                        grant_q <= 1'b0;
                    end else begin
                        tail_q <= tail_q - 2'd1;
                    end
`endif
                end
`ifdef STARVE_GUARD_EN
                RESUME: begin
                    // Second boundary guarantees the CPU one full cycle.
                    if (boundary) begin
                        if (seen_q) state_q <= IDLE;
                        else        seen_q  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    halt_q  <= 1'b1;
                    grant_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ab_out    = grant_q ? bus.dma_addr : bus.cpu_addr;
    assign bus.rw_out    = grant_q | bus.cpu_rw;
    assign bus.halt_b    = halt_q;
    assign bus.dma_grant = grant_q;
    assign bus.dma_latch = latch_q;
    assign bus.wr_block  = grant_q | latch_q;
    assign bus.cs_rd     = (grant_q | latch_q) ? cs_q : bus.cs_in;
    assign bus.starved   = starved_q;
    assign dbg_state_o   = state_q;
    assign dbg_burst_o   = burst_q;
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an ownership model.
`timescale 1ns/1ps
module tb_sysbus_arbiter;
    localparam int TAIL  = 2;
    localparam int MAXB  = 8;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    logic [7:0] dbg_burst;
    bit         rand_bus = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;

    sysbus_arbiter_if #(.CS_W(4)) bus ();

    sysbus_arbiter #(.CS_W(4), .TAIL_CYCLES(TAIL), .MAX_BURST(MAXB)) dut (
        .sysclk_7_143(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state_o(dbg_state),
        .dbg_burst_o(dbg_burst)
    );

    always #5 clk = ~clk;

    // ownership model: halted / granted flags, remaining tail, resume boundary count
    bit         m_halted, m_granted, m_latch, m_starved, m_cut, m_p0;
    int         m_tail, m_resume, m_burst;
    logic [3:0] m_cs_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_halted = 0; m_granted = 0; m_latch = 0; m_starved = 0; m_cut = 0; m_p0 = 0;
        m_tail = -1; m_resume = -1; m_burst = 0; m_cs_prev = 4'h0;
    endtask

    task automatic model_update();
        bit req, bnd, n_latch, n_starved;
        int b;
        req = bus.dma_req;
        bnd = bus.pclk_0 && !m_p0;
        n_latch = m_granted;
        n_starved = 0;
        if (m_resume >= 0) begin
            if (bnd) m_resume = (m_resume == 1) ? -1 : 1;
        end else if (!m_halted) begin
            if (req) m_halted = 1;
        end else if (!m_granted) begin
            if (!req) m_halted = 0;
            else if (bnd) begin m_granted = 1; m_burst = 0; end
        end else if (m_tail < 0) begin
            b = m_burst;
            m_burst = (b < 255) ? b + 1 : 255;
            if (GUARD && b == MAXB - 1) begin m_tail = TAIL - 1; m_cut = 1; n_starved = 1; end
            else if (!req) m_tail = TAIL - 1;
        end else begin
            if (req && !m_cut) m_tail = -1;
            else if (m_tail == 0) begin
                m_granted = 0; m_halted = 0; m_tail = -1;
                if (m_cut) begin m_cut = 0; m_resume = 0; end
            end else m_tail--;
        end
        m_latch = n_latch;
        m_starved = n_starved;
        m_cs_prev = bus.cs_in;
        m_p0 = bus.pclk_0;
    endtask

    task automatic compare_all();
        chk("halt_b",    bus.halt_b,    !m_halted);
        chk("dma_grant", bus.dma_grant, m_granted);
        chk("dma_latch", bus.dma_latch, m_latch);
        chk("wr_block",  bus.wr_block,  m_granted || m_latch);
        chk("starved",   bus.starved,   m_starved);
        chk("ab_out",    bus.ab_out,    m_granted ? bus.dma_addr : bus.cpu_addr);
        chk("rw_out",    bus.rw_out,    m_granted ? 1'b1 : bus.cpu_rw);
        chk("cs_rd",     bus.cs_rd,     (m_granted || m_latch) ? m_cs_prev : bus.cs_in);
    endtask

    task automatic step(input logic r, input logic p);
        @(negedge clk);
        bus.dma_req = r;
        bus.pclk_0  = p;
        bus.cs_in   = 4'($urandom_range(0, 15));
        if (rand_bus) begin
            bus.dma_addr = 16'($urandom);
            bus.cpu_addr = 16'($urandom);
            bus.cpu_rw   = 1'($urandom_range(0, 1));
        end
        #1 compare_all();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        int ph_cnt, ph_len, req_left;
        logic req, p;

        bus.dma_req = 1'b1; bus.pclk_0 = 1'b0; bus.dma_addr = 16'h8000;
        bus.cpu_addr = 16'h1234; bus.cpu_rw = 1'b0; bus.cs_in = 4'hA;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halt_b", bus.halt_b, 1'b1);
        chk("rst_grant",  bus.dma_grant, 1'b0);
        chk("rst_ab_out", bus.ab_out, 16'h1234);
        chk("rst_latch",  bus.dma_latch, 1'b0);
        chk("rst_starved", bus.starved, 1'b0);
        chk("rst_cs_rd",  bus.cs_rd, 4'hA);
        chk("rst_state",  dbg_state, 3'd0);
        rst = 1'b0;

        // request two cycles ahead of a phi0 rise
        step(1, 0); #1 chk("sync_halt_low", bus.halt_b, 1'b0);
        step(1, 0); #1 chk("sync_no_grant", bus.dma_grant, 1'b0);
        step(1, 1); #1;
        chk("grant_high", bus.dma_grant, 1'b1);
        chk("grant_ab",   bus.ab_out, 16'h8000);
        chk("grant_rw",   bus.rw_out, 1'b1);
        step(1, 1); step(1, 0); step(1, 0); step(1, 1);
        step(0, 0); #1 chk("tail1_grant", bus.dma_grant, 1'b1);
        step(0, 0); #1 chk("tail2_grant", bus.dma_grant, 1'b1);
        step(0, 0); #1;
        chk("tail_end_grant", bus.dma_grant, 1'b0);
        chk("tail_end_latch", bus.dma_latch, 1'b1);
        chk("tail_end_wrblk", bus.wr_block, 1'b1);
        chk("tail_end_halt",  bus.halt_b, 1'b1);
        step(0, 0); #1 chk("latch_clear", bus.wr_block, 1'b0);

        // one-cycle request pulse, then drop coinciding with a boundary
        step(1, 0); #1 chk("pulse_halt_low", bus.halt_b, 1'b0);
        step(0, 0); #1 chk("pulse_halt_back", bus.halt_b, 1'b1);
        step(1, 0);
        step(0, 1); #1;
        chk("drop_wins_grant", bus.dma_grant, 1'b0);
        chk("drop_wins_halt",  bus.halt_b, 1'b1);

        // asynchronous reset in the middle of a burst
        step(1, 0); step(1, 0); step(1, 1); step(1, 0);
        #1 chk("pre_rst_grant", bus.dma_grant, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("arst_ab_out", bus.ab_out, 16'h1234);
        chk("arst_grant",  bus.dma_grant, 1'b0);
        chk("arst_halt",   bus.halt_b, 1'b1);
        chk("arst_latch",  bus.dma_latch, 1'b0);
        chk("arst_state",  dbg_state, 3'd0);
        model_reset();
        rst = 1'b0;

        // randomized traffic with irregular phi0 periods
        rand_bus = 1'b1;
        ph_cnt = 0; ph_len = 4; req_left = 0; req = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (ph_cnt == 0) ph_len = ($urandom_range(0, 1) != 0) ? 6 : 4;
            p = (ph_cnt < ph_len / 2);
            ph_cnt = (ph_cnt + 1) % ph_len;
            if (req_left == 0) begin
                req = ~req;
                req_left = req ? $urandom_range(1, 24) : $urandom_range(1, 8);
            end
            req_left--;
            step(req, p);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
